// File: rtl/dvi_timing_pkg.sv
// Shared types, XGA timing defaults and the IDF=3 (RGB 555, 12-bit DDR) pixel packer
// for the CH7301C DVI transmitter controller.
package dvi_timing_pkg;

  typedef enum logic [1:0] {V_SYNC, V_BP, V_ACTIVE, V_FP} vstate_e;
  typedef enum logic [1:0] {H_SYNC, H_BP, H_DATA, H_FP} hstate_e;

  localparam int XGA_HORI_FRONT_PORCH  = 24;
  localparam int XGA_HORI_SYNC_PULSE   = 136;
  localparam int XGA_HORI_BACK_PORCH   = 160;
  localparam int XGA_HORI_VISIBLE_AREA = 1024;
  localparam int XGA_VERT_FRONT_PORCH  = 3;
  localparam int XGA_VERT_SYNC_PULSE   = 6;
  localparam int XGA_VERT_BACK_PORCH   = 29;
  localparam int XGA_VERT_VISIBLE_AREA = 768;

  localparam int PIX_W  = 15;
  localparam int WORD_W = 12;

  typedef struct packed {
    logic [WORD_W-1:0] rise;
    logic [WORD_W-1:0] fall;
  } dvi_word_t;

  // IDF=3: rising edge carries P0b = {0, R, G[4:3]}, falling edge P0a = {G[2:0], B};
  // the low nibble of each word is unused by the 555 format.
  function automatic dvi_word_t pack_idf3(input logic [PIX_W-1:0] pix);
    dvi_word_t w;
    w.rise = {1'b0, pix[14:10], pix[9:8], 4'b0000};
    w.fall = {pix[7:5], pix[4:0], 4'b0000};
    return w;
  endfunction

endpackage

// File: rtl/dvi_video_controller_if.sv
// Pixel stream from the frame-buffer reader into the DVI controller (valid/ready).
interface dvi_video_controller_if;
  import dvi_timing_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/video_timing_gen.sv
// Frame/line counters with vertical and horizontal phase decode; emits the phase
// flags that the output registers will present on the next cycle.
module video_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int HORI_FRONT_PORCH  = XGA_HORI_FRONT_PORCH,
  parameter int HORI_SYNC_PULSE   = XGA_HORI_SYNC_PULSE,
  parameter int HORI_BACK_PORCH   = XGA_HORI_BACK_PORCH,
  parameter int HORI_VISIBLE_AREA = XGA_HORI_VISIBLE_AREA,
  parameter int VERT_FRONT_PORCH  = XGA_VERT_FRONT_PORCH,
  parameter int VERT_SYNC_PULSE   = XGA_VERT_SYNC_PULSE,
  parameter int VERT_BACK_PORCH   = XGA_VERT_BACK_PORCH,
  parameter int VERT_VISIBLE_AREA = XGA_VERT_VISIBLE_AREA
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic nxt_de,
  output logic nxt_h,
  output logic nxt_v,
  output logic nxt_frame_start
);

  localparam int HWHOLE = HORI_FRONT_PORCH + HORI_SYNC_PULSE + HORI_BACK_PORCH + HORI_VISIBLE_AREA;
  localparam int VWHOLE = VERT_FRONT_PORCH + VERT_SYNC_PULSE + VERT_BACK_PORCH + VERT_VISIBLE_AREA;
  localparam int HW = $clog2(HWHOLE);
  localparam int VW = $clog2(VWHOLE);

  localparam logic [HW-1:0] H_LAST       = HW'(HWHOLE - 1);
  localparam logic [HW-1:0] H_BP_START   = HW'(HORI_SYNC_PULSE);
  localparam logic [HW-1:0] H_DATA_START = HW'(HORI_SYNC_PULSE + HORI_BACK_PORCH);
  localparam logic [HW-1:0] H_FP_START   = HW'(HORI_SYNC_PULSE + HORI_BACK_PORCH + HORI_VISIBLE_AREA);
  localparam logic [VW-1:0] V_LAST       = VW'(VWHOLE - 1);
  localparam logic [VW-1:0] V_BP_START   = VW'(VERT_SYNC_PULSE);
  localparam logic [VW-1:0] V_ACT_START  = VW'(VERT_SYNC_PULSE + VERT_BACK_PORCH);
  localparam logic [VW-1:0] V_FP_START   = VW'(VERT_SYNC_PULSE + VERT_BACK_PORCH + VERT_VISIBLE_AREA);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          running;
  vstate_e       vstate;
  hstate_e       hstate;
  logic          last_col;
  logic          frame_end;

  always_comb begin
    vstate = V_FP;
    if (vcnt < V_BP_START)       vstate = V_SYNC;
    else if (vcnt < V_ACT_START) vstate = V_BP;
    else if (vcnt < V_FP_START)  vstate = V_ACTIVE;
  end

  always_comb begin
    hstate = H_FP;
    if (hcnt < H_BP_START)        hstate = H_SYNC;
    else if (hcnt < H_DATA_START) hstate = H_BP;
    else if (hcnt < H_FP_START)   hstate = H_DATA;
  end

  assign last_col  = (hcnt == H_LAST);
  assign frame_end = last_col && (vcnt == V_LAST);

  // en is only honoured while idle or on the last cycle of a frame, so frames never truncate
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else if (!running) begin
      running <= en;
    end else if (frame_end) begin
      running <= en;
      hcnt    <= '0;
      vcnt    <= '0;
    end else if (last_col) begin
      hcnt <= '0;
      vcnt <= vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Horizontal phases exist only in V_ACTIVE, so blanking lines carry no hsync.
  assign nxt_v           = running && (vstate == V_SYNC);
  assign nxt_h           = running && (vstate == V_ACTIVE) && (hstate == H_SYNC);
  assign nxt_de          = running && (vstate == V_ACTIVE) && (hstate == H_DATA);
  assign nxt_frame_start = running && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/dvi_video_controller.sv
// CH7301C DVI controller: pulls pixels on the timing generator's data phase, packs
// them to IDF=3 DDR half-words and registers all pin-level outputs.
module dvi_video_controller
  import dvi_timing_pkg::*;
#(
  parameter int HORI_FRONT_PORCH  = XGA_HORI_FRONT_PORCH,
  parameter int HORI_SYNC_PULSE   = XGA_HORI_SYNC_PULSE,
  parameter int HORI_BACK_PORCH   = XGA_HORI_BACK_PORCH,
  parameter int HORI_VISIBLE_AREA = XGA_HORI_VISIBLE_AREA,
  parameter int VERT_FRONT_PORCH  = XGA_VERT_FRONT_PORCH,
  parameter int VERT_SYNC_PULSE   = XGA_VERT_SYNC_PULSE,
  parameter int VERT_BACK_PORCH   = XGA_VERT_BACK_PORCH,
  parameter int VERT_VISIBLE_AREA = XGA_VERT_VISIBLE_AREA,
  parameter int SYNC_POLARITY     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  dvi_video_controller_if.slave  pix,
  output logic                   frame_start,
  output logic                   underflow,
  input  logic                   underflow_clr,
  output logic [WORD_W-1:0]      dvi_data_rise,
  output logic [WORD_W-1:0]      dvi_data_fall,
  output logic                   dvi_de,
  output logic                   dvi_h,
  output logic                   dvi_v,
  output logic                   dvi_reset_b
);

  localparam logic SYNC_ACT = (SYNC_POLARITY != 0);

  logic      nxt_de;
  logic      nxt_h;
  logic      nxt_v;
  logic      nxt_frame_start;
  logic      miss_p0;
  dvi_word_t word_p0;

  video_timing_gen #(
    .HORI_FRONT_PORCH  (HORI_FRONT_PORCH),
    .HORI_SYNC_PULSE   (HORI_SYNC_PULSE),
    .HORI_BACK_PORCH   (HORI_BACK_PORCH),
    .HORI_VISIBLE_AREA (HORI_VISIBLE_AREA),
    .VERT_FRONT_PORCH  (VERT_FRONT_PORCH),
    .VERT_SYNC_PULSE   (VERT_SYNC_PULSE),
    .VERT_BACK_PORCH   (VERT_BACK_PORCH),
    .VERT_VISIBLE_AREA (VERT_VISIBLE_AREA)
  ) u_timing (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .nxt_de          (nxt_de),
    .nxt_h           (nxt_h),
    .nxt_v           (nxt_v),
    .nxt_frame_start (nxt_frame_start)
  );

  // Fetch stage: a missing pixel becomes black instead of stalling the raster.
  assign pix.pix_ready = nxt_de;
  assign miss_p0       = nxt_de && !pix.pix_valid;
  assign word_p0       = (nxt_de && pix.pix_valid) ? pack_idf3(pix.pix_data) : '0;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      dvi_h         <= ~SYNC_ACT;
      dvi_v         <= ~SYNC_ACT;
      dvi_de        <= 1'b0;
      dvi_data_rise <= '0;
      dvi_data_fall <= '0;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      dvi_reset_b   <= 1'b0;
    end else begin
      dvi_h         <= nxt_h ? SYNC_ACT : ~SYNC_ACT;
      dvi_v         <= nxt_v ? SYNC_ACT : ~SYNC_ACT;
      dvi_de        <= nxt_de;
      dvi_data_rise <= word_p0.rise;
      dvi_data_fall <= word_p0.fall;
      frame_start   <= nxt_frame_start;
      dvi_reset_b   <= 1'b1;
      if (miss_p0)            underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_video_controller.sv
// Scoreboard bench for dvi_video_controller on a reduced 17x8 raster, with an
// active-low and an active-high instance driven by the same stimulus.
module tb_dvi_video_controller;

  localparam int HFP = 2, HS = 3, HBP = 4, HVIS = 8;
  localparam int VFP = 1, VS = 2, VBP = 2, VVIS = 3;
  localparam int HWH = HFP + HS + HBP + HVIS;
  localparam int VWH = VFP + VS + VBP + VVIS;
  localparam int FRAME = HWH * VWH;

  typedef struct {
    logic [11:0] rise;
    logic [11:0] fall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [14:0] pix_data = '0;
  logic        pix_valid = 1'b0;

  logic        fs1, uf1, de1, h1, v1, rb1;
  logic        fs2, uf2, de2, h2, v2, rb2;
  logic [11:0] rise1, fall1, rise2, fall2;

  dvi_video_controller_if pif1 ();
  dvi_video_controller_if pif2 ();
  assign pif1.pix_data  = pix_data;
  assign pif1.pix_valid = pix_valid;
  assign pif2.pix_data  = pix_data;
  assign pif2.pix_valid = pix_valid;

  dvi_video_controller #(
    .HORI_FRONT_PORCH(HFP), .HORI_SYNC_PULSE(HS), .HORI_BACK_PORCH(HBP), .HORI_VISIBLE_AREA(HVIS),
    .VERT_FRONT_PORCH(VFP), .VERT_SYNC_PULSE(VS), .VERT_BACK_PORCH(VBP), .VERT_VISIBLE_AREA(VVIS),
    .SYNC_POLARITY(0)
  ) dut_lo (
    .clk(clk), .rst(rst), .en(en), .pix(pif1), .frame_start(fs1), .underflow(uf1),
    .underflow_clr(underflow_clr), .dvi_data_rise(rise1), .dvi_data_fall(fall1),
    .dvi_de(de1), .dvi_h(h1), .dvi_v(v1), .dvi_reset_b(rb1)
  );

  dvi_video_controller #(
    .HORI_FRONT_PORCH(HFP), .HORI_SYNC_PULSE(HS), .HORI_BACK_PORCH(HBP), .HORI_VISIBLE_AREA(HVIS),
    .VERT_FRONT_PORCH(VFP), .VERT_SYNC_PULSE(VS), .VERT_BACK_PORCH(VBP), .VERT_VISIBLE_AREA(VVIS),
    .SYNC_POLARITY(1)
  ) dut_hi (
    .clk(clk), .rst(rst), .en(en), .pix(pif2), .frame_start(fs2), .underflow(uf2),
    .underflow_clr(underflow_clr), .dvi_data_rise(rise2), .dvi_data_fall(fall2),
    .dvi_de(de2), .dvi_h(h2), .dvi_v(v2), .dvi_reset_b(rb2)
  );

  int   tests = 0;
  int   fails = 0;
  bit   check_on = 0;
  bit   clr_rand = 0;
  int   px_idx = 0;
  exp_t q[$];

  // Reference model: position within the frame (0..FRAME-1) plus a running flag.
  bit   m_running = 0;
  int   m_pos = 0;
  logic e_h = 0, e_v = 0, e_de = 0, e_fs = 0, e_uf = 0, e_rb = 0;

  function automatic bit in_active(int p);
    int line = p / HWH;
    return (line >= VS + VBP) && (line < VS + VBP + VVIS);
  endfunction
  function automatic bit pos_v(int p);
    return (p / HWH) < VS;
  endfunction
  function automatic bit pos_h(int p);
    return in_active(p) && (p % HWH) < HS;
  endfunction
  function automatic bit pos_de(int p);
    int col = p % HWH;
    return in_active(p) && col >= HS + HBP && col < HS + HBP + HVIS;
  endfunction

  function automatic exp_t ref_pack(logic [14:0] p);
    int v, r, g, b;
    exp_t w;
    v = int'(p);
    r = (v >> 10) & 31;
    g = (v >> 5) & 31;
    b = v & 31;
    w.rise = 12'((r << 6) | ((g >> 3) << 4));
    w.fall = 12'(((g & 7) << 9) | (b << 4));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    exp_t w;
    @(posedge clk);
    if (rst) begin
      {e_h, e_v, e_de, e_fs, e_uf, e_rb} = '0;
      m_running = 0;
      m_pos = 0;
    end else begin
      e_rb = 1;
      e_v  = m_running && pos_v(m_pos);
      e_h  = m_running && pos_h(m_pos);
      e_de = m_running && pos_de(m_pos);
      e_fs = m_running && (m_pos == 0);
      if (e_de) begin
        if (pix_valid) w = ref_pack(pix_data);
        else begin w.rise = '0; w.fall = '0; end
        q.push_back(w);
      end
      if (e_de && !pix_valid) e_uf = 1;
      else if (underflow_clr)  e_uf = 0;
      if (!m_running) begin
        m_running = en;
      end else if (m_pos == FRAME - 1) begin
        m_running = en;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Monitor: compares pins every cycle and pops the scoreboard whenever DE is presented.
  initial forever begin
    exp_t w;
    @(negedge clk);
    if (check_on) begin
      chk("v_lo", v1, !e_v);      chk("v_hi", v2, e_v);
      chk("h_lo", h1, !e_h);      chk("h_hi", h2, e_h);
      chk("de_lo", de1, e_de);    chk("de_hi", de2, e_de);
      chk("frame_start", fs1, e_fs);
      chk("frame_start_hi", fs2, e_fs);
      chk("underflow", uf1, e_uf);
      chk("underflow_hi", uf2, e_uf);
      chk("reset_b", rb1, e_rb);  chk("reset_b_hi", rb2, e_rb);
      chk("pix_ready", pif1.pix_ready, m_running && pos_de(m_pos));
      chk("pix_ready_hi", pif2.pix_ready, m_running && pos_de(m_pos));
      chk("exclusive_hi", 32'(h2) + 32'(v2) + 32'(de2) <= 1, 1);
      chk("exclusive_lo", 32'(!h1) + 32'(!v1) + 32'(de1) <= 1, 1);
      if (de1) begin
        if (q.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          w = q.pop_front();
          chk("rise_lo", rise1, w.rise); chk("fall_lo", fall1, w.fall);
          chk("rise_hi", rise2, w.rise); chk("fall_hi", fall2, w.fall);
        end
      end else begin
        chk("rise_blank", rise1, 0); chk("fall_blank", fall1, 0);
        chk("rise_blank_hi", rise2, 0); chk("fall_blank_hi", fall2, 0);
      end
    end
  end

  task automatic drive_cycle(input int vpct, input bit drop_l1p5);
    bit rdy;
    rdy = m_running && pos_de(m_pos);
    pix_data  = 15'($urandom);
    pix_valid = ($urandom_range(99) < vpct);
    if (rdy) begin
      if (px_idx == 0)      pix_data = 15'h7C00;
      else if (px_idx == 1) pix_data = 15'h03E0;
      else if (px_idx == 2) pix_data = 15'h001F;
      px_idx++;
      if (drop_l1p5 && (m_pos / HWH) == VS + VBP + 1 && (m_pos % HWH) == HS + HBP + 5)
        pix_valid = 1'b0;
    end
    underflow_clr = clr_rand && ($urandom_range(19) == 0);
    @(negedge clk);
  endtask

  task automatic wait_pos(input int target, input int vpct);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_running && m_pos == target) begin hit = 1; break; end
      drive_cycle(vpct, 0);
    end
    chk("wait_frame_pos", hit, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_on = 1;
    rst = 0;
    repeat (5) drive_cycle(100, 0);

    en = 1;
    repeat (2 * FRAME + 5) drive_cycle(100, 1);

    clr_rand = 1;
    repeat (FRAME) drive_cycle(85, 0);
    clr_rand = 0;
    underflow_clr = 1;
    @(negedge clk);
    underflow_clr = 0;

    wait_pos(60, 90);
    en = 0;
    repeat (FRAME + 20) drive_cycle(90, 0);
    chk("idle_after_en_low", m_running, 0);
    en = 1;
    repeat (FRAME / 2) drive_cycle(95, 0);

    wait_pos(80, 95);
    rst = 1;
    repeat (2) drive_cycle(95, 0);
    rst = 0;
    repeat (FRAME + 20) drive_cycle(95, 0);

    en = 0;
    repeat (FRAME + 5) drive_cycle(100, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
